// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
// Runtime reprogramming sequencer for a Cyclone V reconfigurable PLL.
// Accepts a counter set over valid/ready, writes it to the reconfig
// controller's management port (MODE, N, M, C*, K, START), then waits for
// the PLL to re-lock or time out.
module pll_reconfig_seq #(
   parameter int NUM_CLOCKS   = 1,
   parameter int LOCK_STABLE  = 16,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_cfg_valid,
   output logic                       o_cfg_ready,
   input  logic [17:0]                i_cfg_n,
   input  logic [17:0]                i_cfg_m,
   input  logic [31:0]                i_cfg_k,
   input  logic                       i_cfg_k_en,
   input  logic [18*NUM_CLOCKS-1:0]   i_cfg_c,
   input  logic [NUM_CLOCKS-1:0]      i_cfg_c_mask,
   output logic [5:0]                 o_mgmt_address,
   output logic                       o_mgmt_write,
   output logic [31:0]                o_mgmt_writedata,
   input  logic                       i_mgmt_waitrequest,
   input  logic                       i_pll_locked,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_error
);

   localparam int ST_W = $clog2(LOCK_STABLE + 1);
   localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [ST_W-1:0] ST_MAX = ST_W'(LOCK_STABLE);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(LOCK_TIMEOUT);

   localparam logic [5:0] A_MODE  = 6'h00;
   localparam logic [5:0] A_START = 6'h02;
   localparam logic [5:0] A_N     = 6'h03;
   localparam logic [5:0] A_M     = 6'h04;
   localparam logic [5:0] A_C     = 6'h05;
   localparam logic [5:0] A_K     = 6'h07;

   typedef enum logic [2:0] {
      S_IDLE, S_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_K, S_START, S_LOCK_WAIT
   } state_t;

   state_t                       r_state;
   logic                         r_busy;
   logic                         r_done;
   logic                         r_error;
   logic                         r_wr;
   logic [5:0]                   r_addr;
   logic [31:0]                  r_data;

   // Request captured at acceptance
   logic [17:0]                  r_n;
   logic [17:0]                  r_m;
   logic [31:0]                  r_k;
   logic                         r_k_en;
   logic [NUM_CLOCKS-1:0][17:0]  r_c;
   logic [NUM_CLOCKS-1:0]        r_c_mask;

   // C counter currently being written
   logic [4:0]                   r_c_idx;
   logic [17:0]                  r_c_sel;

   logic [ST_W-1:0]              r_stable;
   logic [TO_W-1:0]              r_tout;
   logic                         r_lock_s1;
   logic                         r_lock_s2;

   int                           w_c_from;
   logic                         w_c_found;
   logic [4:0]                   w_c_idx;
   logic [17:0]                  w_c_data;
   logic [5:0]                   w_addr;
   logic [31:0]                  w_data;
   state_t                       w_after;

   assign o_cfg_ready      = ~r_busy;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_error          = r_error;
   assign o_mgmt_write     = r_wr;
   assign o_mgmt_address   = r_addr;
   assign o_mgmt_writedata = r_data;

   // Two-flop synchroniser for the asynchronous lock indication
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lock_s1 <= 1'b0;
         r_lock_s2 <= 1'b0;
      end else begin
         r_lock_s1 <= i_pll_locked;
         r_lock_s2 <= r_lock_s1;
      end
   end

   // Lowest enabled C counter above the one just written (from 0 outside WR_C)
   always_comb begin
      w_c_found = 1'b0;
      w_c_idx   = 5'd0;
      w_c_data  = 18'd0;
      w_c_from  = (r_state == S_WR_C) ? int'(r_c_idx) + 1 : 0;
      for (int i = NUM_CLOCKS - 1; i >= 0; i--) begin
         if (r_c_mask[i] && (i >= w_c_from)) begin
            w_c_found = 1'b1;
            w_c_idx   = 5'(i);
            w_c_data  = r_c[i];
         end
      end
   end

   // Address/data for the write belonging to the current state
   always_comb begin
      w_addr = 6'd0;
      w_data = 32'd0;
      case (r_state)
         S_MODE:  begin w_addr = A_MODE;  w_data = 32'd0;                       end
         S_WR_N:  begin w_addr = A_N;     w_data = {14'b0, r_n};                end
         S_WR_M:  begin w_addr = A_M;     w_data = {14'b0, r_m};                end
         S_WR_C:  begin w_addr = A_C;     w_data = {9'b0, r_c_idx, r_c_sel};    end
         S_WR_K:  begin w_addr = A_K;     w_data = r_k;                         end
         S_START: begin w_addr = A_START; w_data = 32'd1;                       end
         default: begin w_addr = 6'd0;    w_data = 32'd0;                       end
      endcase
   end

   // State that follows once the current write completes
   always_comb begin
      w_after = S_IDLE;
      case (r_state)
         S_MODE:          w_after = S_WR_N;
         S_WR_N:          w_after = S_WR_M;
         S_WR_M, S_WR_C:  w_after = w_c_found ? S_WR_C : (r_k_en ? S_WR_K : S_START);
         S_WR_K:          w_after = S_START;
         S_START:         w_after = S_LOCK_WAIT;
         default:         w_after = S_IDLE;
      endcase
   end

   // Sequencer: each write is an assert phase held through waitrequest,
   // followed by exactly one deasserted gap cycle that loads the next write
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_wr     <= 1'b0;
         r_addr   <= 6'd0;
         r_data   <= 32'd0;
         r_n      <= 18'd0;
         r_m      <= 18'd0;
         r_k      <= 32'd0;
         r_k_en   <= 1'b0;
         r_c      <= '0;
         r_c_mask <= '0;
         r_c_idx  <= 5'd0;
         r_c_sel  <= 18'd0;
         r_stable <= '0;
         r_tout   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_cfg_valid) begin
                  r_n      <= i_cfg_n;
                  r_m      <= i_cfg_m;
                  r_k      <= i_cfg_k;
                  r_k_en   <= i_cfg_k_en;
                  r_c      <= i_cfg_c;
                  r_c_mask <= i_cfg_c_mask;
                  r_error  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_MODE;
                  // MODE write goes out immediately, no leading gap
                  r_wr     <= 1'b1;
                  r_addr   <= A_MODE;
                  r_data   <= 32'd0;
               end
            end
            S_LOCK_WAIT: begin
               if (r_stable == ST_MAX) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_error <= 1'b0;
               end else if (r_tout == TO_MAX) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_error <= 1'b1;
               end else begin
                  r_stable <= r_lock_s2 ? r_stable + 1'b1 : '0;
                  r_tout   <= r_tout + 1'b1;
               end
            end
            default: begin
               if (!r_wr) begin
                  r_wr   <= 1'b1;
                  r_addr <= w_addr;
                  r_data <= w_data;
               end else if (!i_mgmt_waitrequest) begin
                  r_wr    <= 1'b0;
                  r_addr  <= 6'd0;
                  r_data  <= 32'd0;
                  r_state <= w_after;
                  if (w_after == S_WR_C) begin
                     r_c_idx <= w_c_idx;
                     r_c_sel <= w_c_data;
                  end
                  if (w_after == S_LOCK_WAIT) begin
                     r_stable <= '0;
                     r_tout   <= '0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

- Runtime reprogramming sequencer for a Cyclone V reconfigurable PLL. It accepts a new counter set (N, M, fractional K, up to NUM_CLOCKS C counters) over a valid/ready handshake.
- It writes the counter set to the PLL reconfiguration controller's Avalon-MM management port in a fixed order, issues START, then waits for the PLL to re-lock.
- It sits between core control logic (e.g. memory-clock frequency selection) and the altera_pll_reconfig instance feeding the PLL's reconfig_to_pll/reconfig_from_pll buses.

## Interface

- NUM_CLOCKS, 1: number of C output counters addressable (1..18).
- LOCK_STABLE, 16: consecutive synced-locked cycles required to declare lock.
- LOCK_TIMEOUT, 65535: cycles allowed in lock wait before error.

- clk  in  1  management clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  request valid
- cfg_ready  out  1  high only in IDLE
- cfg_n  in  18  {odd, bypass, hi[7:0], lo[7:0]}
- cfg_m  in  18  same format as cfg_n
- cfg_k  in  32  fractional K value
- cfg_k_en  in  1  write K when 1
- cfg_c  in  18*NUM_CLOCKS  C counter i at bits [18*i+17:18*i]
- cfg_c_mask  in  NUM_CLOCKS  bit i set: write C counter i
- mgmt_address  out  6  reconfig register address
- mgmt_write  out  1  write strobe
- mgmt_writedata  out  32  write data
- mgmt_waitrequest  in  1  controller stall
- pll_locked  in  1  PLL locked; asynchronous to clk
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence (success or error)
- error  out  1  lock timeout; sticky until next accepted request

## Operation

- Handshake: request accepted on the clk edge where cfg_valid && cfg_ready. All cfg_* fields are registered at acceptance; later input changes are ignored. cfg_valid while busy is held off (cfg_ready=0), never dropped or queued.
- States: IDLE -> MODE -> WR_N -> WR_M -> WR_C -> WR_K -> START -> LOCK_WAIT -> IDLE.
- Register writes, in order:
  - MODE: addr 0x00, data 0 (waitrequest mode).
  - WR_N: addr 0x03, data {14'b0, n}.
  - WR_M: addr 0x04, data {14'b0, m}.
  - WR_C: addr 0x05, data {9'b0, i[4:0], c_i}, one write per set mask bit, ascending i; skipped when the mask is all zeros.
  - WR_K: addr 0x07, data k; skipped when cfg_k_en=0.
  - START: addr 0x02, data 1.
- Write rule:
  - mgmt_write, mgmt_address and mgmt_writedata stay stable while mgmt_waitrequest=1.
  - A write completes on the edge where mgmt_write=1 && mgmt_waitrequest=0.
  - mgmt_write is then low for exactly one cycle before the next write.
  - When idle, mgmt_address and mgmt_writedata are 0.
- pll_locked passes through a 2-flop synchroniser before use.
- LOCK_WAIT:
  - The stable counter increments while synced lock=1 and clears to 0 on lock=0.
  - Success when the stable counter reaches LOCK_STABLE.
  - The timeout counter starts at 0 on entry. Error when it reaches LOCK_TIMEOUT without success.
  - A lock that never drops counts as success after LOCK_STABLE cycles.
- Exit from LOCK_WAIT: done pulses for 1 cycle, error = timeout outcome, and the state returns to IDLE in the same cycle.
- Counters are sized $clog2(param+1). Counter arithmetic saturates, never wraps.

## Timing

- Reset values: cfg_ready=1, busy=0, done=0, error=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, state IDLE, all counters 0.
- Reset mid-sequence: all outputs return to reset values asynchronously. No write is completed and no done pulse is produced. The caller must re-issue the full request.
- busy rises the cycle after acceptance and falls in the same cycle done pulses. cfg_ready = !busy.
- First mgmt_write asserts the cycle after acceptance.
- Sequence length with zero waitrequest: 2 cycles per write (assert + gap). Writes = 4 + popcount(mask) + cfg_k_en.
- LOCK_WAIT is entered the cycle after START completes. The synchroniser adds 2 cycles to lock observation.
- A new request may be accepted in the cycle after done.

## Test plan

- Reset: with rst_n=0, all outputs are at reset values. Release reset, hold 10 cycles idle: no mgmt_write.
- NUM_CLOCKS=2, mask=2'b11, k_en=1, waitrequest=0, locked=1:
  - Addresses 0x00,0x03,0x04,0x05,0x05,0x07,0x02 appear in order.
  - C1 data bits[22:18]=1.
  - done arrives LOCK_STABLE+2 cycles after START.
  - error=0.
- mgmt_waitrequest held high 3 cycles during WR_M: address/data/write stable for 4 cycles, then one gap cycle, then C write. Sequence otherwise unchanged.
- mask=0, k_en=0: only addresses 0x00,0x03,0x04,0x02 are written.
- locked drops after START and returns after 100 cycles, with a 5-cycle glitch low at cycle 50: stable counter restarts, done arrives after 16 clean cycles, error=0.
- locked held low, LOCK_TIMEOUT=1000: done and error=1 at timeout cycle 1000. Next accepted request clears error.
- rst_n pulsed low during the second C write: mgmt_write=0 and busy=0 immediately. New request restarts from the MODE write.
